// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_pkg                                                 |
// | Brief   : Shared func codes, FSM state type and op classifiers for   |
// |           the HI/LO multiply/divide unit and its decoder.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Iterative operations that occupy the unit for 33 cycles.
  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Any of the eight codes this unit responds to.
  function automatic logic is_unit_op(input logic [5:0] op);
    return is_muldiv_op(op) || (op == OP_MFHI) || (op == OP_MTHI) ||
           (op == OP_MFLO) || (op == OP_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_if                                                  |
// | Brief   : Command / result bundle between execute stage and the      |
// |           multiply/divide unit.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface muldiv_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        busy;
  logic [31:0] rd_val;
  logic        rd_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, rs_val, rt_val,
    input  stall, busy, rd_val, rd_valid, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output stall, busy, rd_val, rd_valid, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_step                                                |
// | Brief   : One unsigned iteration: shift-add multiply or restoring    |
// |           shift-subtract divide on a 64-bit {upper,lower} acc.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_step (
  input  logic        div_i,   // 1: divide step, 0: multiply step
  input  logic [63:0] acc_i,   // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  input  logic [31:0] opnd_i,  // multiplicand or divisor magnitude
  output logic [63:0] acc_o
);
  logic [32:0] w_sum;
  logic [33:0] w_diff;
  logic        w_unused_diff;

  // Multiply adds the multiplicand when the lsb is set, then shifts the
  // 65-bit {carry,acc} right; divide shifts the remainder left and keeps
  // the subtraction whenever it does not borrow.
  always_comb begin
    w_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    w_diff = {1'b0, acc_i[63:31]} - {2'b00, opnd_i};
    acc_o  = {w_sum, acc_i[31:1]};
    if (div_i) begin
      if (!w_diff[33]) begin
        acc_o = {w_diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {acc_i[62:0], 1'b0};
      end
    end
  end

  // The remainder never reaches the divisor, so bit 32 of a kept
  // difference is always zero.
  assign w_unused_diff = w_diff[32];

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_ctrl                                                |
// | Brief   : HI/LO multiply/divide unit: 32-iteration sequencer, sign   |
// |           fix-up, MFHI/MFLO/MTHI/MTLO access and pipeline stall.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  muldiv_if.slave   bus
);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;       // result (product / quotient) negative
  logic        rneg_q, rneg_d;     // remainder takes dividend's sign
  logic        is_div_q, is_div_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_busy;
  logic        w_sa, w_sb;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_op_div;
  logic [63:0] w_step_acc;
  logic [63:0] w_prod_neg;
  logic [31:0] w_quot, w_rem;

  assign w_busy   = (state_q != ST_IDLE);
  assign w_sa     = is_signed_op(bus.op) & bus.rs_val[31];
  assign w_sb     = is_signed_op(bus.op) & bus.rt_val[31];
  assign w_a_mag  = w_sa ? (~bus.rs_val + 32'd1) : bus.rs_val;
  assign w_b_mag  = w_sb ? (~bus.rt_val + 32'd1) : bus.rt_val;
  assign w_op_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

  assign w_prod_neg = ~acc_q + 64'd1;
  assign w_quot     = neg_q  ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
  assign w_rem      = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  muldiv_step u_step (
    .div_i  (state_q == ST_DIV),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (w_step_acc)
  );

  // Next-state logic: accept commands in IDLE, iterate, then fix signs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && is_muldiv_op(bus.op)) begin
          cnt_d    = 5'd0;
          neg_d    = w_sa ^ w_sb;
          rneg_d   = w_sa;
          is_div_d = w_op_div;
          dbz_d    = w_op_div && (bus.rt_val == 32'd0);
          if (w_op_div) begin
            state_d = ST_DIV;
            acc_d   = {32'd0, w_a_mag};
            opnd_d  = w_b_mag;
          end else begin
            state_d = ST_MUL;
            acc_d   = {32'd0, w_b_mag};
            opnd_d  = w_a_mag;
          end
        end else if (bus.start && (bus.op == OP_MTHI)) begin
          hi_d = bus.rs_val;
        end else if (bus.start && (bus.op == OP_MTLO)) begin
          lo_d = bus.rs_val;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = w_step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERATIONS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (is_div_q) begin
          lo_d = dbz_q ? 32'hFFFF_FFFF : w_quot;
          hi_d = w_rem;
        end else begin
          {hi_d, lo_d} = neg_q ? w_prod_neg : acc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural register update; reset aborts any operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Combinational outputs; reset_n gating keeps read/stall quiet in reset.
  always_comb begin
    bus.busy        = w_busy;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
    bus.div_by_zero = (state_q == ST_FIX) && dbz_q;
    bus.stall       = reset_n && bus.start && w_busy && is_unit_op(bus.op);
    bus.rd_valid    = reset_n && bus.start && !w_busy &&
                      ((bus.op == OP_MFHI) || (bus.op == OP_MFLO));
    bus.rd_val      = 32'd0;
    if (bus.rd_valid) begin
      bus.rd_val = (bus.op == OP_MFHI) ? hi_q : lo_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_muldiv_ctrl                                             |
// | Brief   : Scoreboard bench for muldiv_ctrl with random commands and  |
// |           an arithmetic reference model.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  res_t        resq[$];
  logic [31:0] rdq[$];
  logic [31:0] m_hi, m_lo;
  int          blo, bhi;   // expected busy window, in cycle numbers

  muldiv_if bus ();

  muldiv_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic, straight from the operation definitions.
  function automatic res_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa, sb, q, m;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dbz = 1'b0;
    r.hi  = 32'd0;
    r.lo  = 32'd0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          r.dbz = 1'b1;
          r.lo  = 32'hFFFF_FFFF;
          r.hi  = a;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          m = sa % sb;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Drive one command from posedge+1, hold it while stalled, return at
  // posedge+1 after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic exp_st;
    bit   done;
    int   waited;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        r = model(op, a, b);
        resq.push_back(r);
        m_hi = r.hi;
        m_lo = r.lo;
      end
      OP_MFHI: rdq.push_back(m_hi);
      OP_MFLO: rdq.push_back(m_lo);
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
    done   = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clock);
      exp_st = is_unit_op(op) && (cyc >= blo) && (cyc <= bhi);
      chk("stall", {63'd0, bus.stall}, {63'd0, exp_st});
      if (!exp_st) begin
        done = 1'b1;
        if (is_muldiv_op(op)) begin
          blo = cyc + 1;
          bhi = cyc + 33;
        end
      end
      @(posedge clock);
      #1;
      waited++;
      if (!done && waited > 60) begin
        chk("accept_timeout", 64'(waited), 64'd0);
        done = 1'b1;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin : monitor
    res_t e;
    bit   prev_busy;
    int   busy_len, dbz_cnt;
    logic dbz_last;
    prev_busy = 0;
    busy_len  = 0;
    dbz_cnt   = 0;
    dbz_last  = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_busy = 0;
        busy_len  = 0;
        dbz_cnt   = 0;
        dbz_last  = 0;
      end else begin
        if (bus.rd_valid) begin
          if (rdq.size() == 0) begin
            chk("rd_unexpected", {63'd0, bus.rd_valid}, 64'd0);
          end else begin
            chk("rd_val", {32'd0, bus.rd_val}, {32'd0, rdq.pop_front()});
          end
        end else if (bus.rd_val !== 32'd0) begin
          chk("rd_val_idle", {32'd0, bus.rd_val}, 64'd0);
        end
        if (bus.busy) begin
          busy_len++;
          dbz_cnt  += int'(bus.div_by_zero);
          dbz_last  = bus.div_by_zero;
        end else if (bus.div_by_zero) begin
          chk("dbz_outside_busy", 64'd1, 64'd0);
        end
        if (prev_busy && !bus.busy) begin
          if (resq.size() == 0) begin
            chk("res_unexpected", 64'd1, 64'd0);
          end else begin
            e = resq.pop_front();
            chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
            chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            chk("busy_len", 64'(busy_len), 64'd33);
            chk("dbz_pulse", {31'd0, dbz_last, 32'(dbz_cnt)}, {31'd0, e.dbz, 31'd0, e.dbz});
          end
          busy_len = 0;
          dbz_cnt  = 0;
          dbz_last = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : driver
    logic [5:0] op;
    n_cmp = 0;
    n_bad = 0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    blo   = 1;
    bhi   = 0;
    bus.start  = 1'b0;
    bus.op     = 6'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    reset_n = 1'b1;
    idle(1);

    // Directed cases.
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    issue(OP_MFHI, 32'd0, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);
    issue(OP_MULT, 32'd6, 32'd7);
    idle(4);
    issue(OP_MFLO, 32'd0, 32'd0);
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(OP_DIV, 32'h1234, 32'd0);
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd0);
    issue(OP_MTHI, 32'hCAFE, 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_MFHI, 32'd0, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(6'b100000, 32'h5555, 32'h1);          // foreign op while busy
    issue(OP_MTLO, 32'h1357_9BDF, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);

    // Reset in the middle of a divide.
    issue(OP_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) @(posedge clock);
    #2;
    reset_n    = 1'b0;
    bus.start  = 1'b1;
    bus.op     = OP_MFHI;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_hi", {32'd0, bus.hi}, 64'd0);
    chk("arst_lo", {32'd0, bus.lo}, 64'd0);
    chk("arst_rd", {31'd0, bus.rd_valid, bus.rd_val}, 64'd0);
    chk("arst_stall", {63'd0, bus.stall}, 64'd0);
    chk("arst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    resq.delete();
    rdq.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    blo  = 1;
    bhi  = 0;
    bus.start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(1);
    issue(OP_MULT, 32'd2, 32'd3);
    issue(OP_MFHI, 32'd0, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: issue(OP_MULT,  rnd_val(), rnd_val());
        1: issue(OP_MULTU, rnd_val(), rnd_val());
        2: issue(OP_DIV,   rnd_val(), rnd_val());
        3: issue(OP_DIVU,  rnd_val(), rnd_val());
        4: issue(OP_MFHI,  rnd_val(), rnd_val());
        5: issue(OP_MTHI,  rnd_val(), rnd_val());
        6: issue(OP_MFLO,  rnd_val(), rnd_val());
        7: issue(OP_MTLO,  rnd_val(), rnd_val());
        8: begin
          op = 6'($urandom);
          if (is_unit_op(op)) op = 6'b100001;
          issue(op, rnd_val(), rnd_val());
        end
        default: idle($urandom_range(1, 40));
      endcase
    end

    // Drain outstanding expectations with a bounded wait.
    for (int k = 0; k < 100 && (resq.size() != 0 || rdq.size() != 0); k++) begin
      @(negedge clock);
    end
    chk("drain_res", 64'(resq.size()), 64'd0);
    chk("drain_rd", 64'(rdq.size()), 64'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
